// File: rtl/lea_xor_stream.sv
// LEA decrypt XOR stage: per-word block^key with optional key folding into the
// top word, registered into a DEPTH-entry FIFO on a valid/ready stream.
module lea_xor_stream #(
  parameter int unsigned WORD   = 32,
  parameter int unsigned NWORDS = 4,
  parameter int unsigned KWORDS = 6,
  parameter int unsigned DEPTH  = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       InValid,
  output logic                       InReady,
  input  logic [NWORDS*WORD-1:0]     Din,
  input  logic [KWORDS*WORD-1:0]     RoundKey,
  input  logic                       Fold,
  output logic                       OutValid,
  input  logic                       OutReady,
  output logic [NWORDS*WORD-1:0]     Dout,
  output logic [$clog2(DEPTH):0]     Count
);

  localparam int unsigned BW  = NWORDS * WORD;
  localparam int unsigned PW  = $clog2(DEPTH);
  localparam int unsigned CW  = PW + 1;
  localparam int unsigned TOP = (NWORDS - 1) * WORD;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [BW-1:0]   mem_q [DEPTH];
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q,  count_d;
  logic [WORD-1:0] fold_x;
  logic [BW-1:0]   result;
  logic            push, pop;

  // Low words and the top word's own key word come from one wide XOR; the
  // extra key words above NWORDS-1 are folded into the top word on demand.
  always_comb begin
    fold_x = '0;
    for (int unsigned k = NWORDS; k < KWORDS; k++) begin
      fold_x ^= RoundKey[k*WORD +: WORD];
    end
    result = Din ^ RoundKey[BW-1:0];
    if (Fold) begin
      result[TOP +: WORD] = result[TOP +: WORD] ^ fold_x;
    end
  end

  // OutReady reaches InReady combinationally so a full buffer can still take
  // a beat on the same edge it releases one.
  assign OutValid = (count_q != '0);
  assign InReady  = !rst && ((count_q < FULL) || OutReady);
  assign push     = InValid && InReady;
  assign pop      = OutValid && OutReady;
  assign Dout     = OutValid ? mem_q[rd_ptr_q] : '0;
  assign Count    = count_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + PW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= result;
  end

endmodule

// File: tb/tb_lea_xor_stream.sv
// Bench for lea_xor_stream: default and (2,2,4) instances against a queue model.
module tb_lea_xor_stream;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  logic         a_vld, a_rdy, a_fold, a_ovld, a_ordy;
  logic [127:0] a_din, a_dout;
  logic [191:0] a_key;
  logic [1:0]   a_cnt;

  logic         b_vld, b_rdy, b_fold, b_ovld, b_ordy;
  logic [63:0]  b_din, b_dout, b_key;
  logic [2:0]   b_cnt;

  int checks = 0;
  int errors = 0;
  bit started = 1'b0;

  logic [127:0] qa[$];
  logic [127:0] qb[$];

  localparam logic [127:0] D0     = {32'd4, 32'd3, 32'd2, 32'd1};
  localparam logic [191:0] K0     = {32'h60, 32'h50, 32'h40, 32'h30, 32'h20, 32'h10};
  localparam logic [127:0] R_FOLD = {32'h74, 32'h33, 32'h22, 32'h11};
  localparam logic [127:0] R_NOF  = {32'h44, 32'h33, 32'h22, 32'h11};

  lea_xor_stream #(.WORD(32), .NWORDS(4), .KWORDS(6), .DEPTH(2)) dut_a (
    .clk(clk), .rst(rst), .InValid(a_vld), .InReady(a_rdy), .Din(a_din),
    .RoundKey(a_key), .Fold(a_fold), .OutValid(a_ovld), .OutReady(a_ordy),
    .Dout(a_dout), .Count(a_cnt)
  );

  lea_xor_stream #(.WORD(32), .NWORDS(2), .KWORDS(2), .DEPTH(4)) dut_b (
    .clk(clk), .rst(rst), .InValid(b_vld), .InReady(b_rdy), .Din(b_din),
    .RoundKey(b_key), .Fold(b_fold), .OutValid(b_ovld), .OutReady(b_ordy),
    .Dout(b_dout), .Count(b_cnt)
  );

  function automatic logic [127:0] xform(input logic [127:0] d, input logic [191:0] k,
                                         input int n, input int kw, input logic fold);
    logic [127:0] r;
    r = '0;
    for (int i = 0; i < n; i++) r[i*32 +: 32] = d[i*32 +: 32] ^ k[i*32 +: 32];
    if (fold) for (int j = n; j < kw; j++) r[(n-1)*32 +: 32] = r[(n-1)*32 +: 32] ^ k[j*32 +: 32];
    return r;
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Transaction-level model: acceptance and release decided from queue depth.
  always @(posedge clk) begin : model
    bit pa, ua, pb, ub;
    if (rst) begin
      qa.delete();
      qb.delete();
    end else begin
      pa = (qa.size() != 0) && a_ordy;
      ua = a_vld && ((qa.size() < 2) || a_ordy);
      pb = (qb.size() != 0) && b_ordy;
      ub = b_vld && ((qb.size() < 4) || b_ordy);
      if (pa) void'(qa.pop_front());
      if (ua) qa.push_back(xform(a_din, a_key, 4, 6, a_fold));
      if (pb) void'(qb.pop_front());
      if (ub) qb.push_back(xform({64'b0, b_din}, {128'b0, b_key}, 2, 2, b_fold));
    end
  end

  always @(negedge clk) begin
    if (started) begin
      chk("a_in_ready",  {127'b0, a_rdy},  {127'b0, (!rst && ((qa.size() < 2) || a_ordy))});
      chk("a_out_valid", {127'b0, a_ovld}, {127'b0, (qa.size() != 0)});
      chk("a_dout",      a_dout,           (qa.size() != 0) ? qa[0] : '0);
      chk("a_count",     {126'b0, a_cnt},  128'(qa.size()));
      chk("b_in_ready",  {127'b0, b_rdy},  {127'b0, (!rst && ((qb.size() < 4) || b_ordy))});
      chk("b_out_valid", {127'b0, b_ovld}, {127'b0, (qb.size() != 0)});
      chk("b_dout",      {64'b0, b_dout},  (qb.size() != 0) ? qb[0] : '0);
      chk("b_count",     {125'b0, b_cnt},  128'(qb.size()));
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    a_vld = 0; a_fold = 0; a_ordy = 0; a_din = '0; a_key = '0;
    b_vld = 0; b_fold = 0; b_ordy = 0; b_din = '0; b_key = '0;
    tick;
    started = 1'b1;
    tick;
    rst = 1'b0;
    @(negedge clk);
    chk("lit_reset_count", {126'b0, a_cnt}, 128'd0);
    chk("lit_reset_valid", {127'b0, a_ovld}, 128'd0);
    chk("lit_reset_dout", a_dout, 128'd0);

    // single beats, fold on then off
    a_din = D0; a_key = K0; a_fold = 1; a_ordy = 1; a_vld = 1;
    tick;
    a_vld = 0;
    @(negedge clk);
    chk("lit_fold_on", a_dout, R_FOLD);
    chk("lit_fold_on_count", {126'b0, a_cnt}, 128'd1);
    tick;
    @(negedge clk);
    chk("lit_drained_count", {126'b0, a_cnt}, 128'd0);
    a_fold = 0; a_vld = 1;
    tick;
    a_vld = 0;
    @(negedge clk);
    chk("lit_fold_off", a_dout, R_NOF);
    tick;

    // 8 back-to-back beats with alternating Fold
    for (int i = 0; i < 8; i++) begin
      a_din = {32'd4, 32'd3, 32'd2, 32'(i + 1)};
      a_fold = (i % 2 == 0);
      a_vld = 1;
      @(negedge clk);
      chk("lit_stream_ready", {127'b0, a_rdy}, 128'd1);
      if (i > 0) chk("lit_stream_top", {96'b0, a_dout[127:96]},
                     (((i - 1) % 2) == 0) ? 128'h74 : 128'h44);
      tick;
    end
    a_vld = 0;
    tick;

    // backpressure with full buffer
    a_ordy = 0; a_fold = 1; a_key = K0;
    a_din = {32'd4, 32'd3, 32'd2, 32'h101}; a_vld = 1;
    tick;
    a_din = {32'd4, 32'd3, 32'd2, 32'h102};
    tick;
    a_din = {32'd4, 32'd3, 32'd2, 32'h103};
    @(negedge clk);
    chk("lit_full_count", {126'b0, a_cnt}, 128'd2);
    chk("lit_full_ready", {127'b0, a_rdy}, 128'd0);
    tick;
    @(negedge clk);
    chk("lit_full_held", {127'b0, a_rdy}, 128'd0);
    tick;
    a_ordy = 1;
    @(negedge clk);
    chk("lit_full_release", {127'b0, a_rdy}, 128'd1);
    tick;
    a_vld = 0;
    @(negedge clk);
    chk("lit_swap_count", {126'b0, a_cnt}, 128'd2);
    chk("lit_swap_head", {96'b0, a_dout[31:0]}, 128'h112);
    tick; tick;

    // stall stability while inputs churn
    a_ordy = 0; a_din = {32'd4, 32'd3, 32'd2, 32'h55}; a_vld = 1;
    tick;
    a_vld = 0;
    for (int s = 0; s < 5; s++) begin
      a_din = {$urandom, $urandom, $urandom, $urandom};
      a_key = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      a_fold = ~a_fold;
      @(negedge clk);
      chk("lit_stall_dout", a_dout, {32'h74, 32'h33, 32'h22, 32'h45});
      tick;
    end
    a_ordy = 1;
    tick;

    // reset mid-stream
    a_ordy = 0; a_key = K0; a_fold = 1;
    a_din = {32'd4, 32'd3, 32'd2, 32'h201}; a_vld = 1;
    tick;
    a_din = {32'd4, 32'd3, 32'd2, 32'h202};
    tick;
    rst = 1; a_din = {32'd4, 32'd3, 32'd2, 32'h203};
    @(negedge clk);
    chk("lit_rst_ready", {127'b0, a_rdy}, 128'd0);
    chk("lit_rst_count_before", {126'b0, a_cnt}, 128'd2);
    tick;
    rst = 0;
    @(negedge clk);
    chk("lit_rst_valid", {127'b0, a_ovld}, 128'd0);
    chk("lit_rst_dout", a_dout, 128'd0);
    chk("lit_rst_count", {126'b0, a_cnt}, 128'd0);
    tick;
    a_vld = 0;
    @(negedge clk);
    chk("lit_post_rst_count", {126'b0, a_cnt}, 128'd1);
    chk("lit_post_rst_dout", a_dout, {32'h74, 32'h33, 32'h22, 32'h213});
    a_ordy = 1;
    tick;

    // NWORDS=KWORDS=2, DEPTH=4 instance
    b_din = {32'hF0, 32'h01}; b_key = {32'h0F, 32'h02}; b_fold = 1; b_ordy = 1; b_vld = 1;
    tick;
    b_vld = 0;
    @(negedge clk);
    chk("lit_b_fold_on", {64'b0, b_dout}, {64'b0, 32'hFF, 32'h03});
    tick;
    b_fold = 0; b_vld = 1;
    tick;
    b_vld = 0;
    @(negedge clk);
    chk("lit_b_fold_off", {64'b0, b_dout}, {64'b0, 32'hFF, 32'h03});
    tick;
    b_ordy = 0; b_fold = 1;
    for (int n = 0; n < 4; n++) begin
      b_din = {32'hF0, 32'(n)}; b_vld = 1;
      tick;
    end
    b_din = {32'hF0, 32'd4};
    @(negedge clk);
    chk("lit_b_full_count", {125'b0, b_cnt}, 128'd4);
    chk("lit_b_full_ready", {127'b0, b_rdy}, 128'd0);
    tick;
    b_ordy = 1;
    @(negedge clk);
    chk("lit_b_release", {127'b0, b_rdy}, 128'd1);
    tick;
    b_vld = 0;
    @(negedge clk);
    chk("lit_b_swap_count", {125'b0, b_cnt}, 128'd4);
    chk("lit_b_swap_head", {96'b0, b_dout[31:0]}, 128'h3);
    tick; tick; tick; tick;
    @(negedge clk);
    chk("lit_b_drained", {125'b0, b_cnt}, 128'd0);
    tick;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
